// File: rtl/fwd_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit_pkg
// Purpose  : RV32I opcode constants, register-index width and the
//            in-flight destination record type shared by the forwarding
//            and hazard logic.
// Revision : 1.0 - initial release
// ============================================================================
package fwd_hazard_unit_pkg;

    // RV32I major opcodes (inst[6:0])
    localparam logic [6:0] c_OP_LUI       = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] c_OP_JAL       = 7'b1101111;
    localparam logic [6:0] c_OP_JALR      = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD      = 7'b0000011;
    localparam logic [6:0] c_OP_STORE     = 7'b0100011;
    localparam logic [6:0] c_OP_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] c_OP_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] c_OP_FENCE     = 7'b0001111;
    localparam logic [6:0] c_OP_CSR       = 7'b1110011;

    // Register index width
    localparam int c_REG_W = 5;

    // One in-flight destination record
    typedef struct packed {
        logic               valid;
        logic [c_REG_W-1:0] rd;
        logic               is_load;
    } fwd_rec_t;

endpackage : fwd_hazard_unit_pkg
`default_nettype wire

// File: rtl/fwd_hazard_unit_inst_reg_use.sv
`default_nettype none
// ============================================================================
// Module   : inst_reg_use
// Purpose  : Combinational RV32I register-usage decoder. Reports whether an
//            instruction writes rd, reads rs1/rs2, and whether it is a load.
//            Unrecognised opcodes report no register usage at all.
// Ports    : i_inst     in  32  instruction word
//            o_has_rd   out 1   writes a non-x0 destination
//            o_has_rs1  out 1   reads rs1
//            o_has_rs2  out 1   reads rs2
//            o_is_load  out 1   LOAD opcode
//            o_rd/o_rs1/o_rs2 out 5  register index fields
// Revision : 1.0 - initial release
// ============================================================================
module inst_reg_use
    import fwd_hazard_unit_pkg::*;
(
    input  logic [31:0]        i_inst,
    output logic               o_has_rd,
    output logic               o_has_rs1,
    output logic               o_has_rs2,
    output logic               o_is_load,
    output logic [c_REG_W-1:0] o_rd,
    output logic [c_REG_W-1:0] o_rs1,
    output logic [c_REG_W-1:0] o_rs2
);

    logic [6:0] w_opcode;
    logic       w_rd_nz;

    assign w_opcode = i_inst[6:0];
    assign o_rd     = i_inst[11:7];
    assign o_rs1    = i_inst[19:15];
    assign o_rs2    = i_inst[24:20];
    assign w_rd_nz  = (i_inst[11:7] != '0);

    always_comb begin
        o_has_rd  = 1'b0;
        o_has_rs1 = 1'b0;
        o_has_rs2 = 1'b0;
        o_is_load = 1'b0;
        case (w_opcode)
            c_OP_LUI, c_OP_AUIPC, c_OP_JAL: begin
                o_has_rd = w_rd_nz;
            end
            c_OP_JALR, c_OP_ARI_ITYPE, c_OP_FENCE: begin
                o_has_rd  = w_rd_nz;
                o_has_rs1 = 1'b1;
            end
            c_OP_LOAD: begin
                o_has_rd  = w_rd_nz;
                o_has_rs1 = 1'b1;
                o_is_load = 1'b1;
            end
            c_OP_ARI_RTYPE: begin
                o_has_rd  = w_rd_nz;
                o_has_rs1 = 1'b1;
                o_has_rs2 = 1'b1;
            end
            c_OP_BRANCH, c_OP_STORE: begin
                o_has_rs1 = 1'b1;
                o_has_rs2 = 1'b1;
            end
            c_OP_CSR: begin
                // funct3[2] set selects the immediate (zimm) CSR forms
                o_has_rd  = w_rd_nz;
                o_has_rs1 = ~i_inst[14];
            end
            default: begin
                o_has_rd  = 1'b0;
            end
        endcase
    end

endmodule : inst_reg_use
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Purpose  : Operand forwarding select and load-use hazard detection for the
//            decode stage. Tracks one destination record per stage after
//            decode (record 1 = execute, the youngest) and counts stall
//            cycles in a saturating counter.
// Ports    : clk, rst_n (sync, active-low)
//            id_valid, id_inst   instruction in decode
//            flush               kill decode instruction this cycle
//            ext_stall           freeze the whole pipeline this cycle
//            rs1_sel, rs2_sel    0 = register file, k = forward from record k
//            hazard_stall        hold decode, bubble into record 1
//            stall_cnt           saturating count of stall cycles
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1),
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_inst,
    input  logic             flush,
    input  logic             ext_stall,
    output logic [SEL_W-1:0] rs1_sel,
    output logic [SEL_W-1:0] rs2_sel,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] stall_cnt
);

    logic               w_has_rd;
    logic               w_has_rs1;
    logic               w_has_rs2;
    logic               w_is_load;
    logic [c_REG_W-1:0] w_rd;
    logic [c_REG_W-1:0] w_rs1;
    logic [c_REG_W-1:0] w_rs2;

    logic               w_rs1_use;
    logic               w_rs2_use;
    logic [SEL_W-1:0]   w_rs1_sel;
    logic [SEL_W-1:0]   w_rs2_sel;
    logic               w_rs1_ld_wait;
    logic               w_rs2_ld_wait;
    logic               w_hazard;
    fwd_rec_t           w_new_rec;

    fwd_rec_t           r_rec [1:DEPTH];
    logic [CNT_W-1:0]   r_cnt;

    inst_reg_use u_dec (
        .i_inst    (id_inst),
        .o_has_rd  (w_has_rd),
        .o_has_rs1 (w_has_rs1),
        .o_has_rs2 (w_has_rs2),
        .o_is_load (w_is_load),
        .o_rd      (w_rd),
        .o_rs1     (w_rs1),
        .o_rs2     (w_rs2)
    );

    // x0 is excluded here so a read of x0 can never pick up a forward
    assign w_rs1_use = id_valid && w_has_rs1 && (w_rs1 != '0);
    assign w_rs2_use = id_valid && w_has_rs2 && (w_rs2 != '0);

    // Priority encoders: scan oldest to youngest so the last hit (smallest k)
    // wins. The load-wait flag follows the winning record only.
    always_comb begin
        w_rs1_sel     = '0;
        w_rs2_sel     = '0;
        w_rs1_ld_wait = 1'b0;
        w_rs2_ld_wait = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (w_rs1_use && r_rec[k].valid && (r_rec[k].rd == w_rs1)) begin
                w_rs1_sel     = SEL_W'(k);
                w_rs1_ld_wait = r_rec[k].is_load && (k < LOAD_STAGE);
            end
            if (w_rs2_use && r_rec[k].valid && (r_rec[k].rd == w_rs2)) begin
                w_rs2_sel     = SEL_W'(k);
                w_rs2_ld_wait = r_rec[k].is_load && (k < LOAD_STAGE);
            end
        end
    end

    assign w_hazard = (w_rs1_ld_wait || w_rs2_ld_wait) && !flush;

    // A stalled or flushed decode slot enters the pipe as a bubble
    always_comb begin
        w_new_rec         = '0;
        w_new_rec.valid   = id_valid && w_has_rd && !w_hazard && !flush;
        w_new_rec.rd      = w_rd;
        w_new_rec.is_load = w_is_load;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_rec[k] <= '0;
            end
            r_cnt <= '0;
        end else if (!ext_stall) begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_rec[k] <= r_rec[k-1];
            end
            r_rec[1] <= w_new_rec;
            if (w_hazard && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign rs1_sel      = w_rs1_sel;
    assign rs2_sel      = w_rs2_sel;
    assign hazard_stall = w_hazard;
    assign stall_cnt    = r_cnt;

endmodule : fwd_hazard_unit
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Purpose  : Self-checking bench for fwd_hazard_unit (DEPTH=2, LOAD_STAGE=2,
//            CNT_W=4). A reference model tracks in-flight writers and is
//            compared every cycle; literal expectations pin key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

    localparam int c_DEPTH = 2;
    localparam int c_LS    = 2;
    localparam int c_CNT_W = 4;
    localparam int c_SEL_W = 2;

    logic               clk;
    logic               rst_n;
    logic               id_valid;
    logic [31:0]        id_inst;
    logic               flush;
    logic               ext_stall;
    logic [c_SEL_W-1:0] rs1_sel;
    logic [c_SEL_W-1:0] rs2_sel;
    logic               hazard_stall;
    logic [c_CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    fwd_hazard_unit #(
        .DEPTH      (c_DEPTH),
        .LOAD_STAGE (c_LS),
        .CNT_W      (c_CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_inst      (id_inst),
        .flush        (flush),
        .ext_stall    (ext_stall),
        .rs1_sel      (rs1_sel),
        .rs2_sel      (rs2_sel),
        .hazard_stall (hazard_stall),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instruction builders ----------------
    function automatic logic [31:0] f_add(input int rd, input int a, input int b);
        return {7'b0, 5'(b), 5'(a), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] f_addi(input int rd, input int a, input int imm);
        return {12'(imm), 5'(a), 3'b000, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] f_lw(input int rd, input int a);
        return {12'd0, 5'(a), 3'b010, 5'(rd), 7'b0000011};
    endfunction
    function automatic logic [31:0] f_sw(input int src, input int base);
        return {7'd0, 5'(src), 5'(base), 3'b010, 5'd0, 7'b0100011};
    endfunction
    // LUI whose immediate bits sit where rs1 would be
    function automatic logic [31:0] f_lui(input int rd, input int fake_rs1);
        return {12'd0, 5'(fake_rs1), 3'b000, 5'(rd), 7'b0110111};
    endfunction

    // ---------------- reference model ----------------
    // Register usage straight from the ISA rules
    function automatic void m_decode(input logic [31:0] inst,
                                     output bit wr, output bit u1, output bit u2,
                                     output bit ld);
        logic [6:0] op;
        bit known;
        op = inst[6:0];
        known = (op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                            7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                            7'b0110011, 7'b0001111, 7'b1110011});
        wr = known && !(op inside {7'b1100011, 7'b0100011}) && (inst[11:7] != 0);
        u1 = known && !(op inside {7'b0110111, 7'b0010111, 7'b1101111})
                   && !(op == 7'b1110011 && inst[14]);
        u2 = op inside {7'b1100011, 7'b0100011, 7'b0110011};
        ld = (op == 7'b0000011);
    endfunction

    // In-flight writers: index 1 = youngest
    bit     m_v  [1:c_DEPTH];
    int     m_rd [1:c_DEPTH];
    bit     m_ld [1:c_DEPTH];
    int     m_cnt;

    // Youngest producer of register r, 0 if none
    function automatic int m_find(input int r);
        if (r == 0) return 0;
        for (int k = 1; k <= c_DEPTH; k++)
            if (m_v[k] && m_rd[k] == r) return k;
        return 0;
    endfunction

    function automatic void m_outputs(output int s1, output int s2, output bit st);
        bit wr, u1, u2, ld;
        m_decode(id_inst, wr, u1, u2, ld);
        s1 = (id_valid && u1) ? m_find(int'(id_inst[19:15])) : 0;
        s2 = (id_valid && u2) ? m_find(int'(id_inst[24:20])) : 0;
        st = !flush && (((s1 != 0) && m_ld[s1] && s1 < c_LS) ||
                        ((s2 != 0) && m_ld[s2] && s2 < c_LS));
    endfunction

    always @(posedge clk) begin
        int s1, s2;
        bit st, wr, u1, u2, ld;
        if (!rst_n) begin
            for (int k = 1; k <= c_DEPTH; k++) m_v[k] = 0;
            m_cnt = 0;
        end else if (!ext_stall) begin
            m_outputs(s1, s2, st);
            m_decode(id_inst, wr, u1, u2, ld);
            for (int k = c_DEPTH; k >= 2; k--) begin
                m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
            end
            m_v[1]  = id_valid && wr && !st && !flush;
            m_rd[1] = int'(id_inst[11:7]);
            m_ld[1] = ld;
            if (st && m_cnt < (1 << c_CNT_W) - 1) m_cnt = m_cnt + 1;
        end
    end

    // Every-cycle compare, away from the active edge
    always @(negedge clk) begin
        int s1, s2;
        bit st;
        if (chk_en) begin
            m_outputs(s1, s2, st);
            checks += 4;
            if (int'(rs1_sel) != s1) begin
                errors++;
                $display("FAIL model rs1_sel @%0t actual %0d expected %0d", $time, rs1_sel, s1);
            end
            if (int'(rs2_sel) != s2) begin
                errors++;
                $display("FAIL model rs2_sel @%0t actual %0d expected %0d", $time, rs2_sel, s2);
            end
            if (hazard_stall !== st) begin
                errors++;
                $display("FAIL model hazard_stall @%0t actual %0b expected %0b", $time, hazard_stall, st);
            end
            if (int'(stall_cnt) != m_cnt) begin
                errors++;
                $display("FAIL model stall_cnt @%0t actual %0d expected %0d", $time, stall_cnt, m_cnt);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic apply(input logic v, input logic [31:0] inst,
                         input logic fl = 1'b0, input logic es = 1'b0,
                         input logic rn = 1'b1);
        @(posedge clk);
        #1;
        id_valid  = v;
        id_inst   = inst;
        flush     = fl;
        ext_stall = es;
        rst_n     = rn;
        #2;
    endtask

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        id_valid  = 1'b1;
        id_inst   = f_add(6, 5, 7);
        flush     = 1'b0;
        ext_stall = 1'b0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        #2;
        lit("reset_rs1_sel", int'(rs1_sel), 0);
        lit("reset_rs2_sel", int'(rs2_sel), 0);
        lit("reset_stall", int'(hazard_stall), 0);
        lit("reset_cnt", int'(stall_cnt), 0);

        // Back-to-back ALU dependency
        apply(1, f_add(5, 1, 2));
        apply(1, f_add(6, 5, 7));
        lit("alu_rs1_sel", int'(rs1_sel), 1);
        lit("alu_rs2_sel", int'(rs2_sel), 0);
        lit("alu_stall", int'(hazard_stall), 0);

        // Load-use: one stall, then forward from record 2
        apply(1, f_lw(5, 1));
        apply(1, f_add(6, 7, 5));
        lit("lu_stall_c1", int'(hazard_stall), 1);
        lit("lu_cnt_c1", int'(stall_cnt), 0);
        apply(1, f_add(6, 7, 5));
        lit("lu_rs2_sel_c2", int'(rs2_sel), 2);
        lit("lu_stall_c2", int'(hazard_stall), 0);
        lit("lu_cnt_c2", int'(stall_cnt), 1);

        // x0 writer and x0 reader
        apply(1, f_addi(0, 0, 1));
        apply(1, f_add(1, 0, 0));
        lit("x0_rs1_sel", int'(rs1_sel), 0);
        lit("x0_rs2_sel", int'(rs2_sel), 0);

        // Two writers of x5: youngest wins
        apply(1, f_addi(5, 0, 1));
        apply(1, f_addi(5, 0, 2));
        apply(1, f_add(9, 5, 0));
        lit("multi_rs1_sel", int'(rs1_sel), 1);

        // LUI does not read rs1 even if its immediate looks like x9
        apply(1, f_lui(7, 9));
        lit("lui_rs1_sel", int'(rs1_sel), 0);
        // Store reads rs2
        apply(1, f_sw(7, 1));
        lit("sw_rs2_sel", int'(rs2_sel), 1);
        // Invalid decode slot never selects
        apply(0, f_add(8, 7, 7));
        lit("inval_rs1_sel", int'(rs1_sel), 0);

        // Freeze: writer of x5 in record 1, hold for 3 cycles
        apply(1, f_addi(5, 0, 3));
        for (int i = 0; i < 3; i++) begin
            apply(1, f_add(6, 5, 0), 1'b0, 1'b1);
            lit("freeze_rs1_sel", int'(rs1_sel), 1);
        end
        apply(1, f_add(6, 5, 0));
        lit("unfreeze_rs1_sel", int'(rs1_sel), 1);
        // flush together with ext_stall: records hold
        apply(1, f_add(7, 6, 0), 1'b1, 1'b1);
        lit("flush_frz_rs1_sel", int'(rs1_sel), 1);
        apply(1, f_add(7, 6, 0), 1'b1, 1'b0);

        // Flush kills a load-use stall and bubbles record 1
        apply(1, f_lw(5, 1));
        apply(1, f_add(6, 5, 0), 1'b1, 1'b0);
        lit("flush_stall", int'(hazard_stall), 0);
        lit("flush_rs1_sel", int'(rs1_sel), 1);
        apply(1, f_add(7, 5, 6));
        lit("post_flush_rs1_sel", int'(rs1_sel), 2);
        lit("post_flush_rs2_sel", int'(rs2_sel), 0);
        lit("post_flush_cnt", int'(stall_cnt), 1);

        // Counter saturation: 20 more stalls on top of 1
        for (int i = 0; i < 20; i++) begin
            apply(1, f_lw(5, 1));
            apply(1, f_add(6, 5, 0));
            apply(1, f_add(6, 5, 0));
        end
        lit("sat_cnt", int'(stall_cnt), 15);

        // Reset mid-stream
        apply(1, f_lw(5, 1));
        apply(1, f_add(6, 5, 5), 1'b0, 1'b0, 1'b0);
        apply(1, f_add(6, 5, 5));
        lit("midrst_rs1_sel", int'(rs1_sel), 0);
        lit("midrst_rs2_sel", int'(rs2_sel), 0);
        lit("midrst_stall", int'(hazard_stall), 0);
        lit("midrst_cnt", int'(stall_cnt), 0);

        repeat (2) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fwd_hazard_unit
`default_nettype wire
